y_mc_sequencer: RTL and testbench
=================================

// Module: y_mc_sequencer
// PURPOSE
//  Multi-cycle control FSM for the MIPS-subset datapath (yIF/yID/yEX/yDM/yWB/yPC).
//  Replaces the single-cycle yC1..yC4 decode. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  It drives one shared instr/data memory port through a req/ack handshake and updates PC exactly once per instruction.
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles memReq may wait for memAck before timeout trap
//  CNT_WIDTH     32  width of performance counters (used only with Y_PERF_CNT_EN)
// PORTS
//  clk        in   1   clock, rising edge
//  resetN     in   1   asynchronous active-low reset
//  opCode     in   6   ins[31:26] from instruction register
//  fnCode     in   6   ins[5:0]
//  zero       in   1   ALU zero flag, valid in EXEC
//  INT        in   1   interrupt request, level
//  memAck     in   1   memory access complete this cycle
//  memReq     out  1   memory access request
//  memSel     out  1   0=instruction fetch, 1=data access
//  memWe      out  1   data write (sw)
//  irWrite    out  1   load instruction register
//  pcWrite    out  1   load PC from pcSrc mux
//  pcSrc      out  2   0=PCp4 1=branch target 2=jump target 3=entryPoint
//  RegWrite   out  1   register file write enable
//  RegDst     out  1   1=rd (rtype), 0=rt
//  ALUSrc     out  1   1=imm, 0=rd2
//  op         out  3   ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
//  Mem2Reg    out  1   1=writeback from memOut
//  instRet    out  1   one-cycle pulse per retired instruction
//  illegal    out  1   sticky: undecodable opCode/fnCode
//  memTimeout out  1   sticky: memAck not received in time
//  state      out  3   current state encoding (debug)
//  cycleCnt   out  CNT_WIDTH  cycles since reset (Y_PERF_CNT_EN)
//  retCnt     out  CNT_WIDTH  retired instructions (Y_PERF_CNT_EN)
// BEHAVIOUR
//  Reset: while resetN=0, state=RST and every output=0. First clk after release: RST drives pcWrite=1, pcSrc=3, then goes to FETCH.
//  Decode: rtype=000000, lw=100011, sw=101011, beq=000100, j=000010. Any other opCode -> illegal.
//  rtype fnCode: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Any other fnCode -> illegal.
//  FETCH: memReq=1, memSel=0. Hold until memAck. On the ack cycle, irWrite=1 and go to DECODE.
//  DECODE: 1 cycle. Illegal -> TRAP with illegal set. Otherwise -> EXEC.
//  EXEC: op and ALUSrc asserted for the decoded class (lw/sw: 010, ALUSrc=1; beq: 110, ALUSrc=0).
//    - rtype -> WB.
//    - lw/sw -> MEM.
//    - beq/j retire in this cycle; pcSrc = beq ? (zero?1:0) : 2.
//  MEM: memReq=1, memSel=1, memWe=sw; op/ALUSrc held. On memAck: sw retires; lw -> WB.
//  WB: RegWrite=1; RegDst=rtype; Mem2Reg=lw. Retires.
//  Retire cycle: pcWrite=1, instRet=1, next state FETCH. If INT=1, pcSrc=3 overrides branch/jump/PCp4.
//  INT is sampled only in retire cycles and in TRAP. It is ignored mid-instruction, including during memory waits.
//  Handshake: memReq stays high until the memAck cycle and drops the following cycle. memAck with memReq=0 is ignored.
//  Wait counter: resets on each new request. If MEM_WAIT_MAX cycles pass with no ack -> TRAP, memTimeout=1, memReq drops.
//  TRAP: all strobes 0. Stays in TRAP until INT=1. Then pcWrite=1, pcSrc=3, illegal and memTimeout clear, -> FETCH.
//  resetN low mid-operation: immediate return to RST with all outputs 0, including sticky flags. No memory write completes.
//  Strobes are Moore outputs of state, except pcSrc, irWrite, and retire/MEM exit, which qualify on zero/memAck/INT.
//  Latency in cycles, zero-wait memory: rtype 4, beq/j 3, sw 4, lw 5.
// CONFIGURATION
//  Y_PERF_CNT_EN defined:
//    - cycleCnt increments every cycle after reset.
//    - retCnt increments on instRet.
//    - Both are 0 in reset and wrap modulo 2^CNT_WIDTH.
//  Y_PERF_CNT_EN undefined: cycleCnt and retCnt are tied to 0 and no counter flops are built.
// TESTING
//  1. Reset release, memAck tied 1 -> cycle 1 pcWrite=1, pcSrc=3; cycle 2 memReq=1, memSel=0, irWrite=1.
//  2. add (op 000000, fn 100000), zero-wait -> op=010 in EXEC; WB RegWrite=1, RegDst=1; instRet 4 cycles after FETCH start.
//  3. lw with memAck delayed 3 cycles in MEM -> memReq=1, memSel=1 held 4 cycles; WB Mem2Reg=1; total 8 cycles.
//  4. beq with zero=1, then zero=0 -> pcSrc=1, then 0; pcWrite=1 in EXEC both times; no RegWrite.
//  5. j retire cycle with INT=1 -> pcSrc=3. Opcode 111111 -> TRAP, illegal=1; INT pulse -> pcSrc=3, illegal=0, FETCH.
//  6. memAck held 0 -> TRAP after 15 wait cycles, memTimeout=1. Mid-run resetN=0 -> all outputs 0 same cycle. Y_PERF_CNT_EN: retCnt matches instRet count.

Source files
------------

// File: rtl/y_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the MIPS-subset datapath.
// Optional performance counters are built when Y_PERF_CNT_EN is defined.
module y_mc_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [5:0]           opCode,
  input  logic [5:0]           fnCode,
  input  logic                 zero,
  input  logic                 INT,
  input  logic                 memAck,
  output logic                 memReq,
  output logic                 memSel,
  output logic                 memWe,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic [1:0]           pcSrc,
  output logic                 RegWrite,
  output logic                 RegDst,
  output logic                 ALUSrc,
  output logic [2:0]           op,
  output logic                 Mem2Reg,
  output logic                 instRet,
  output logic                 illegal,
  output logic                 memTimeout,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] cycleCnt,
  output logic [CNT_WIDTH-1:0] retCnt
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;

  logic       is_rtype, is_lw, is_sw, is_beq, is_j;
  logic       fn_ok, dec_illegal;
  logic [2:0] fn_op, alu_op;
  logic       alu_src;
  logic       retire;
  logic [1:0] br_src;

  assign is_rtype = (opCode == 6'b000000);
  assign is_lw    = (opCode == 6'b100011);
  assign is_sw    = (opCode == 6'b101011);
  assign is_beq   = (opCode == 6'b000100);
  assign is_j     = (opCode == 6'b000010);

  always_comb begin
    fn_ok = 1'b1;
    fn_op = 3'b000;
    case (fnCode)
      6'b100000: fn_op = 3'b010;
      6'b100010: fn_op = 3'b110;
      6'b100100: fn_op = 3'b000;
      6'b100101: fn_op = 3'b001;
      6'b101010: fn_op = 3'b111;
      default:   fn_ok = 1'b0;
    endcase
  end

  assign dec_illegal = !(is_lw || is_sw || is_beq || is_j || (is_rtype && fn_ok));

  always_comb begin
    alu_op  = 3'b000;
    alu_src = 1'b0;
    if (is_lw || is_sw) begin
      alu_op  = 3'b010;
      alu_src = 1'b1;
    end else if (is_beq) begin
      alu_op = 3'b110;
    end else if (is_rtype) begin
      alu_op = fn_op;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    retire     = 1'b0;
    br_src     = 2'd0;
    memReq     = 1'b0;
    memSel     = 1'b0;
    memWe      = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 2'd0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    ALUSrc     = 1'b0;
    op         = 3'b000;
    Mem2Reg    = 1'b0;
    instRet    = 1'b0;

    case (state_q)
      // The async reset holds state_q here, so gating by resetN keeps outputs low in reset.
      S_RST: begin
        pcWrite = resetN;
        pcSrc   = resetN ? 2'd3 : 2'd0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        memReq = 1'b1;
        if (memAck) begin
          irWrite = 1'b1;
          state_d = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        op     = alu_op;
        ALUSrc = alu_src;
        if (is_rtype) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          retire = 1'b1;
          br_src = is_beq ? {1'b0, zero} : 2'd2;
        end
      end
      S_MEM: begin
        memReq = 1'b1;
        memSel = 1'b1;
        memWe  = is_sw;
        op     = alu_op;
        ALUSrc = alu_src;
        if (memAck) begin
          if (is_sw) retire = 1'b1;
          else       state_d = S_WB;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = is_rtype;
        Mem2Reg  = is_lw;
        retire   = 1'b1;
      end
      S_TRAP: begin
        if (INT) begin
          pcWrite   = 1'b1;
          pcSrc     = 2'd3;
          illegal_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_RST;
    endcase

    // A pending interrupt redirects the single PC update of the retiring instruction.
    if (retire) begin
      pcWrite = 1'b1;
      instRet = 1'b1;
      pcSrc   = INT ? 2'd3 : br_src;
      state_d = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_RST;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  assign state      = state_q;
  assign illegal    = illegal_q;
  assign memTimeout = timeout_q;

`ifdef Y_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] ret_cnt_q, ret_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 1'b1;
    ret_cnt_d   = ret_cnt_q + {{(CNT_WIDTH-1){1'b0}}, instRet};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cycle_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  assign cycleCnt = cycle_cnt_q;
  assign retCnt   = ret_cnt_q;
`else
  assign cycleCnt = '0;
  assign retCnt   = '0;
`endif

endmodule

// File: tb/tb_y_mc_sequencer.sv
// Directed self-checking bench for y_mc_sequencer: reset, each instruction class,
// interrupts, illegal/timeout traps, mid-run reset and (optionally) perf counters.
module tb_y_mc_sequencer;

  logic        clk;
  logic        resetN;
  logic [5:0]  opCode;
  logic [5:0]  fnCode;
  logic        zero;
  logic        INT;
  logic        memAck;
  logic        memReq, memSel, memWe, irWrite, pcWrite;
  logic [1:0]  pcSrc;
  logic        RegWrite, RegDst, ALUSrc, Mem2Reg, instRet, illegal, memTimeout;
  logic [2:0]  op;
  logic [2:0]  state;
  logic [31:0] cycleCnt, retCnt;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned n_cyc;

  y_mc_sequencer #(.MEM_WAIT_MAX(15), .CNT_WIDTH(32)) dut (
    .clk(clk), .resetN(resetN), .opCode(opCode), .fnCode(fnCode), .zero(zero),
    .INT(INT), .memAck(memAck), .memReq(memReq), .memSel(memSel), .memWe(memWe),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .op(op), .Mem2Reg(Mem2Reg), .instRet(instRet),
    .illegal(illegal), .memTimeout(memTimeout), .state(state),
    .cycleCnt(cycleCnt), .retCnt(retCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) n_cyc <= 0;
    else         n_cyc <= n_cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int n;
    resetN = 1'b0; opCode = 6'b000000; fnCode = 6'b100000;
    zero = 1'b0; INT = 1'b0; memAck = 1'b1;
    repeat (3) tick();
    settle();
    check_val("rst_state", 32'(state), 0);
    check_val("rst_pcwrite", 32'(pcWrite), 0);
    check_val("rst_pcsrc", 32'(pcSrc), 0);
    check_val("rst_memreq", 32'(memReq), 0);

    // Reset release: RST cycle loads entry point, then fetch with immediate ack
    resetN = 1'b1; settle();
    check_val("rel_pcwrite", 32'(pcWrite), 1);
    check_val("rel_pcsrc", 32'(pcSrc), 3);
    tick();
    check_val("fetch_memreq", 32'(memReq), 1);
    check_val("fetch_memsel", 32'(memSel), 0);
    check_val("fetch_irwrite", 32'(irWrite), 1);

    // add: FETCH, DECODE, EXEC, WB
    tick(); check_val("add_decode", 32'(state), 2);
    tick();
    check_val("add_op", 32'(op), 3'b010);
    check_val("add_alusrc", 32'(ALUSrc), 0);
    check_val("add_exec_ret", 32'(instRet), 0);
    tick();
    check_val("add_regwrite", 32'(RegWrite), 1);
    check_val("add_regdst", 32'(RegDst), 1);
    check_val("add_instret", 32'(instRet), 1);
    check_val("add_pcsrc", 32'(pcSrc), 0);
    tick(); check_val("add_next_fetch", 32'(state), 1);

    // lw with three wait cycles in MEM
    opCode = 6'b100011;
    tick(); tick();
    check_val("lw_op", 32'(op), 3'b010);
    check_val("lw_alusrc", 32'(ALUSrc), 1);
    memAck = 1'b0;
    tick();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) memAck = 1'b1;
      settle();
      if (memReq && memSel && !memWe && !instRet) n++;
      if (i < 3) tick();
    end
    check_val("lw_req_cycles", 32'(n), 4);
    tick();
    check_val("lw_mem2reg", 32'(Mem2Reg), 1);
    check_val("lw_regwrite", 32'(RegWrite), 1);
    check_val("lw_regdst", 32'(RegDst), 0);
    check_val("lw_instret", 32'(instRet), 1);
    tick();

    // sw retires in MEM on zero-wait ack
    opCode = 6'b101011;
    tick(); tick(); tick();
    check_val("sw_memwe", 32'(memWe), 1);
    check_val("sw_memsel", 32'(memSel), 1);
    check_val("sw_instret", 32'(instRet), 1);
    check_val("sw_regwrite", 32'(RegWrite), 0);
    tick();

    // beq taken then not taken
    opCode = 6'b000100;
    tick(); tick(); zero = 1'b1; settle();
    check_val("beq1_op", 32'(op), 3'b110);
    check_val("beq1_pcsrc", 32'(pcSrc), 1);
    check_val("beq1_pcwrite", 32'(pcWrite), 1);
    check_val("beq1_regwrite", 32'(RegWrite), 0);
    tick(); check_val("beq1_next_fetch", 32'(state), 1);
    tick(); tick(); zero = 1'b0; settle();
    check_val("beq0_pcsrc", 32'(pcSrc), 0);
    check_val("beq0_pcwrite", 32'(pcWrite), 1);
    tick();

    // j plain, then j with INT in the retire cycle
    opCode = 6'b000010;
    tick(); tick(); settle();
    check_val("j_pcsrc", 32'(pcSrc), 2);
    tick(); tick(); tick(); INT = 1'b1; settle();
    check_val("j_int_pcsrc", 32'(pcSrc), 3);
    check_val("j_int_instret", 32'(instRet), 1);
    tick(); INT = 1'b0; settle();
    check_val("j_int_fetch", 32'(state), 1);

    // undecodable opcode traps until INT
    opCode = 6'b111111;
    tick(); tick();
    check_val("ill_trap_state", 32'(state), 6);
    check_val("ill_flag", 32'(illegal), 1);
    check_val("ill_memreq", 32'(memReq), 0);
    tick(); check_val("ill_trap_hold", 32'(state), 6);
    INT = 1'b1; settle();
    check_val("ill_exit_pcsrc", 32'(pcSrc), 3);
    check_val("ill_exit_pcwrite", 32'(pcWrite), 1);
    tick(); INT = 1'b0; settle();
    check_val("ill_cleared", 32'(illegal), 0);
    check_val("ill_fetch", 32'(state), 1);

    // rtype with an unknown function code
    opCode = 6'b000000; fnCode = 6'b000000;
    tick(); tick();
    check_val("fn_ill_flag", 32'(illegal), 1);
    INT = 1'b1; tick(); INT = 1'b0; fnCode = 6'b100000; settle();
    check_val("fn_ill_cleared", 32'(illegal), 0);

    // fetch timeout after 15 unanswered cycles
    memAck = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      settle();
      if (memReq) n++;
      tick();
    end
    check_val("to_req_cycles", 32'(n), 15);
    check_val("to_state", 32'(state), 6);
    check_val("to_flag", 32'(memTimeout), 1);
    check_val("to_memreq", 32'(memReq), 0);
    INT = 1'b1; memAck = 1'b1; settle();
    check_val("to_exit_pcsrc", 32'(pcSrc), 3);
    tick(); INT = 1'b0; settle();
    check_val("to_cleared", 32'(memTimeout), 0);

`ifdef Y_PERF_CNT_EN
    check_val("perf_retcnt", retCnt, 7);
    check_val("perf_cyclecnt", cycleCnt, n_cyc);
`else
    check_val("perf_retcnt_tied", retCnt, 0);
    check_val("perf_cyclecnt_tied", cycleCnt, 0);
`endif

    // reset while trapped clears the sticky flag at once
    opCode = 6'b111111;
    tick(); tick();
    check_val("rst2_pre_illegal", 32'(illegal), 1);
    resetN = 1'b0; settle();
    check_val("rst2_illegal", 32'(illegal), 0);
    check_val("rst2_state", 32'(state), 0);
    check_val("rst2_retcnt", retCnt, 0);
    tick(); resetN = 1'b1; settle();
    check_val("rst2_rel_pcsrc", 32'(pcSrc), 3);

    // reset during a stalled store drops memWe in the same cycle
    opCode = 6'b101011;
    tick(); tick(); tick(); memAck = 1'b0; tick();
    check_val("rst3_pre_memwe", 32'(memWe), 1);
    resetN = 1'b0; settle();
    check_val("rst3_memwe", 32'(memWe), 0);
    check_val("rst3_memreq", 32'(memReq), 0);
    check_val("rst3_pcwrite", 32'(pcWrite), 0);
    check_val("rst3_state", 32'(state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
